// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl shared definitions: register offsets and CAUSE layout.
// Latency: n/a (constants only).
// Backpressure: n/a.
package irq_ctrl_pkg;

   // Register offsets within the 4-entry window
   localparam logic [1:0] REG_PEND  = 2'd0;
   localparam logic [1:0] REG_MASK  = 2'd1;
   localparam logic [1:0] REG_CAUSE = 2'd2;
   localparam logic [1:0] REG_MODE  = 2'd3;

   // CAUSE register layout: {valid, 4'b0, idx[2:0]}
   localparam int CAUSE_VALID_BIT = 7;
   localparam int IDX_W           = 3;
   localparam int DATA_W          = 8;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder over NUM_SRC request bits.
// Latency: purely combinational.
// Backpressure: none.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic [NUM_SRC-1:0] act_i,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   // Scan from the top down so the lowest set index is the last to write idx_o
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (act_i[i]) begin
            idx_o   = i[IDX_W-1:0];
            valid_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller: edge-latched pending bits, mask, prioritised cause, registered irq.
// Latency: src edge -> pend after 1 clk -> irq after 2 clks; register reads are combinational.
// Backpressure: none; optional level-sensitive sources enabled by IRQ_CTRL_LEVEL_EN.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NUM_SRC = 8
) (
   input  logic               clk,
   input  logic               rst,
   output logic [7:0]         dbr,
   input  logic [7:0]         dbw,
   input  logic [1:0]         addr,
   input  logic               cs,
   input  logic               we,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq
);

   logic [NUM_SRC-1:0] src_q;
   logic [NUM_SRC-1:0] pend_q, pend_d;
   logic [NUM_SRC-1:0] mask_q, mask_d;
   logic               irq_q;
   logic [NUM_SRC-1:0] act;
   logic [NUM_SRC-1:0] edge_set;
   logic [NUM_SRC-1:0] wdat;
   logic [NUM_SRC-1:0] sw_clr;
   logic [NUM_SRC-1:0] sw_set;
   logic [IDX_W-1:0]   cause_idx;
   logic               cause_vld;
   logic [7:0]         cause_dat;
   logic               wr;
`ifdef IRQ_CTRL_LEVEL_EN
   logic [NUM_SRC-1:0] mode_q, mode_d;
`endif

   assign wr       = cs & we;
   assign wdat     = dbw[NUM_SRC-1:0];
   assign edge_set = src & ~src_q;
   assign act      = pend_q & mask_q;
   assign irq      = irq_q;

   irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
      .act_i   (act),
      .idx_o   (cause_idx),
      .valid_o (cause_vld)
   );

   assign cause_dat = {cause_vld, 4'b0000, cause_idx};

   // Pending next state: clear first, then software set and hardware edges override the clear
   always_comb begin
      sw_clr = '0;
      sw_set = '0;
      if (wr && addr == REG_PEND)  sw_clr = wdat;
      if (wr && addr == REG_CAUSE) sw_set = wdat;
      pend_d = (pend_q & ~sw_clr) | sw_set | edge_set;
`ifdef IRQ_CTRL_LEVEL_EN
      // Level-mode bits simply track the source; software writes to them are ignored
      pend_d = (pend_d & ~mode_q) | (src & mode_q);
`endif
   end

   // Mask (and mode) are plain read/write registers
   always_comb begin
      mask_d = mask_q;
      if (wr && addr == REG_MASK) mask_d = wdat;
   end

`ifdef IRQ_CTRL_LEVEL_EN
   // Mode register: 1 selects level sensitivity for that source
   always_comb begin
      mode_d = mode_q;
      if (wr && addr == REG_MODE) mode_d = wdat;
   end

   // Mode state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) mode_q <= '0;
      else      mode_q <= mode_d;
   end
`endif

   // Core state: source history, pending, mask and the registered irq output
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_q  <= '0;
         pend_q <= '0;
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         src_q  <= src;
         pend_q <= pend_d;
         mask_q <= mask_d;
         irq_q  <= |act;
      end
   end

   // Read mux: combinational, side-effect free, zero when not selected
   always_comb begin
      dbr = 8'h00;
      if (cs) begin
         case (addr)
            REG_PEND:  dbr = 8'(pend_q);
            REG_MASK:  dbr = 8'(mask_q);
            REG_CAUSE: dbr = cause_dat;
`ifdef IRQ_CTRL_LEVEL_EN
            REG_MODE:  dbr = 8'(mode_q);
`endif
            default:   dbr = 8'h00;
         endcase
      end
   end

endmodule
